// File: rtl/apu_voice_mixer.sv
// Multi-voice audio generator: per-voice square/saw/noise oscillators with decaying
// envelopes, summed and emitted as a frame-latched 1-bit PWM sound line.
module apu_voice_mixer #(
  parameter int NUM_VOICES  = 3,
  parameter int PERIOD_BITS = 16,
  parameter int AMP_BITS    = 8,
  parameter int ENV_BITS    = 4,
  parameter int MIX_BITS    = AMP_BITS + $clog2(NUM_VOICES + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_VOICES-1:0]             voice_trigger,
  input  logic [2*NUM_VOICES-1:0]           voice_mode,
  input  logic [NUM_VOICES*PERIOD_BITS-1:0] voice_period,
  input  logic                              env_tick,
  output logic [NUM_VOICES-1:0]             active,
  output logic                              sound
);

  localparam logic [ENV_BITS-1:0] ENV_MAX = '1;

  logic [NUM_VOICES*AMP_BITS-1:0] vout_all;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    // Distinct nonzero seed per voice so noise voices do not play in lockstep.
    localparam logic [14:0] SEED = 15'(32'h7FFF - i);

    logic [PERIOD_BITS-1:0]       period;
    logic [PERIOD_BITS-1:0]       phase_q, phase_d;
    logic [1:0]                   mode;
    logic                         wrap;
    logic                         sq_q, sq_d;
    logic [AMP_BITS-1:0]          ramp_q, ramp_d;
    logic [14:0]                  lfsr_q, lfsr_d;
    logic [ENV_BITS-1:0]          env_q, env_d;
    logic [AMP_BITS-1:0]          sample;
    logic [AMP_BITS+ENV_BITS-1:0] scaled;
    logic [AMP_BITS-1:0]          vout_q, vout_d;

    assign period = voice_period[i*PERIOD_BITS +: PERIOD_BITS];
    assign mode   = voice_mode[2*i +: 2];
    // >= so that lowering the period below the current phase wraps immediately.
    assign wrap   = (period != '0) && (phase_q >= period - PERIOD_BITS'(1));

    always_comb begin
      phase_d = phase_q;
      sq_d    = sq_q;
      ramp_d  = ramp_q;
      lfsr_d  = lfsr_q;
      env_d   = env_q;
      if (wrap) begin
        phase_d = '0;
        sq_d    = ~sq_q;
        ramp_d  = ramp_q + AMP_BITS'(1);
        lfsr_d  = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
      end else if (period != '0) begin
        phase_d = phase_q + PERIOD_BITS'(1);
      end
      if (env_tick && (env_q != '0)) env_d = env_q - ENV_BITS'(1);
      // Retrigger overrides decay; ramp and LFSR deliberately keep running.
      if (voice_trigger[i]) begin
        env_d   = ENV_MAX;
        phase_d = '0;
        sq_d    = 1'b1;
      end

      sample = '0;
      case (mode)
        2'b00:   sample = {AMP_BITS{sq_q}};
        2'b01:   sample = ramp_q;
        2'b10:   sample = AMP_BITS'(lfsr_q);
        default: sample = '0;
      endcase
      scaled = {{ENV_BITS{1'b0}}, sample} * {{AMP_BITS{1'b0}}, env_q};
      vout_d = AMP_BITS'(scaled >> ENV_BITS);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        phase_q <= '0;
        sq_q    <= 1'b0;
        ramp_q  <= '0;
        lfsr_q  <= SEED;
        env_q   <= '0;
        vout_q  <= '0;
      end else begin
        phase_q <= phase_d;
        sq_q    <= sq_d;
        ramp_q  <= ramp_d;
        lfsr_q  <= lfsr_d;
        env_q   <= env_d;
        vout_q  <= vout_d;
      end
    end

    assign vout_all[i*AMP_BITS +: AMP_BITS] = vout_q;
    assign active[i] = (env_q != '0);
  end

  // Mixer: MIX_BITS is sized so the full-scale sum cannot overflow.
  logic [MIX_BITS-1:0] mix_sum;
  logic [MIX_BITS-1:0] mix_q, mix_d;
  logic [MIX_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                sound_q, sound_d;

  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      mix_sum = mix_sum + MIX_BITS'(vout_all[v*AMP_BITS +: AMP_BITS]);
    end
    pwm_cnt_d = pwm_cnt_q + MIX_BITS'(1);
    // Latch only at the frame boundary so the duty never changes mid-frame.
    mix_d     = (pwm_cnt_q == '1) ? mix_sum : mix_q;
    sound_d   = (pwm_cnt_q < mix_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mix_q     <= '0;
      pwm_cnt_q <= '0;
      sound_q   <= 1'b0;
    end else begin
      mix_q     <= mix_d;
      pwm_cnt_q <= pwm_cnt_d;
      sound_q   <= sound_d;
    end
  end

  assign sound = sound_q;

endmodule

// File: tb/tb_apu_voice_mixer.sv
// Bench for apu_voice_mixer: directed scenarios plus randomized traffic, checked
// cycle by cycle against an integer reference model of the voice/mixer behaviour.
module tb_apu_voice_mixer;
  localparam int NV    = 3;
  localparam int PB    = 16;
  localparam int AB    = 8;
  localparam int EB    = 4;
  localparam int MB    = 10;
  localparam int FRAME = 1 << MB;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NV-1:0]    voice_trigger = '0;
  logic [2*NV-1:0]  voice_mode = '1;
  logic [NV*PB-1:0] voice_period = '0;
  logic             env_tick = 1'b0;
  logic [NV-1:0]    active;
  logic             sound;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apu_voice_mixer #(
    .NUM_VOICES(NV), .PERIOD_BITS(PB), .AMP_BITS(AB), .ENV_BITS(EB)
  ) dut (
    .clk(clk), .reset(reset), .voice_trigger(voice_trigger), .voice_mode(voice_mode),
    .voice_period(voice_period), .env_tick(env_tick), .active(active), .sound(sound)
  );

  // Reference model state, advanced once per rising edge.
  int m_phase[NV], m_sq[NV], m_ramp[NV], m_lfsr[NV], m_env[NV], m_vout[NV];
  int m_pwm, m_mix, m_sound;

  function automatic int get_mode(int v);
    return int'(voice_mode[2*v +: 2]);
  endfunction

  function automatic int get_period(int v);
    return int'(voice_period[v*PB +: PB]);
  endfunction

  always @(posedge clk) begin
    int sum, samp, per, nxt_sound;
    bit wrap;
    if (reset) begin
      for (int v = 0; v < NV; v++) begin
        m_phase[v] = 0; m_sq[v] = 0; m_ramp[v] = 0;
        m_lfsr[v] = 32'h7FFF - v; m_env[v] = 0; m_vout[v] = 0;
      end
      m_pwm = 0; m_mix = 0; m_sound = 0;
    end else begin
      sum = 0;
      for (int v = 0; v < NV; v++) sum += m_vout[v];
      nxt_sound = (m_pwm < m_mix) ? 1 : 0;
      if (m_pwm == FRAME - 1) m_mix = sum;
      m_pwm   = (m_pwm + 1) % FRAME;
      m_sound = nxt_sound;
      for (int v = 0; v < NV; v++) begin
        case (get_mode(v))
          0:       samp = (m_sq[v] != 0) ? 255 : 0;
          1:       samp = m_ramp[v];
          2:       samp = m_lfsr[v] % 256;
          default: samp = 0;
        endcase
        m_vout[v] = (samp * m_env[v]) / 16;
        per  = get_period(v);
        wrap = (per != 0) && (m_phase[v] >= per - 1);
        if (wrap) begin
          m_phase[v] = 0;
          m_sq[v]    = 1 - m_sq[v];
          m_ramp[v]  = (m_ramp[v] + 1) % 256;
          m_lfsr[v]  = ((m_lfsr[v] * 2) % 32768) | (((m_lfsr[v] >> 14) ^ (m_lfsr[v] >> 13)) & 1);
        end else if (per != 0) begin
          m_phase[v] = m_phase[v] + 1;
        end
        if (env_tick && m_env[v] > 0) m_env[v] = m_env[v] - 1;
        if (voice_trigger[v]) begin
          m_env[v] = 15; m_phase[v] = 0; m_sq[v] = 1;
        end
      end
    end
  end

  function automatic logic [27:0] obs_vec();
    return {sound, active, dut.g_voice[2].vout_q, dut.g_voice[1].vout_q, dut.g_voice[0].vout_q};
  endfunction

  function automatic logic [27:0] exp_vec();
    logic [27:0] e;
    e = '0;
    e[27] = (m_sound != 0);
    for (int v = 0; v < NV; v++) begin
      e[24+v]     = (m_env[v] != 0);
      e[v*8 +: 8] = 8'(m_vout[v]);
    end
    return e;
  endfunction

  task automatic pulse_reset();
    reset = 1'b1; voice_trigger = '0; env_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; voice_mode = '1; voice_period = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (sound !== 1'b0 || active !== 3'b000) begin
      errors++; $display("FAIL reset_outputs: sound=%b active=%b want 0/000", sound, active);
    end
    checks++;
    if (obs_vec() !== 28'h0) begin
      errors++; $display("FAIL reset_state: got %h want 0000000", obs_vec());
    end
    checks++;
    if (dut.g_voice[1].lfsr_q !== 15'h7FFE) begin
      errors++; $display("FAIL reset_seed: got %h want 7ffe", dut.g_voice[1].lfsr_q);
    end
    reset = 1'b0;
  endtask

  task automatic test_square();
    int hi = 0;
    pulse_reset();
    voice_mode = 6'b111100;
    voice_period = '0; voice_period[0 +: PB] = 16'd4;
    voice_trigger = 3'b001;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      voice_trigger = '0;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL square_model cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 1 || c == 5) begin
        checks++;
        if (dut.g_voice[0].vout_q !== ((c == 1) ? 8'hEF : 8'h00)) begin
          errors++; $display("FAIL square_level cyc %0d: got %h want %h", c, dut.g_voice[0].vout_q,
                             (c == 1) ? 8'hEF : 8'h00);
        end
      end
      if (c >= 6 && c < 22 && dut.g_voice[0].vout_q == 8'hEF) hi++;
    end
    checks++;
    if (hi !== 8) begin
      errors++; $display("FAIL square_high_count: got %0d want 8", hi);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (sound !== 1'b0 || active !== 3'b000 || obs_vec() !== 28'h0) begin
      errors++; $display("FAIL reset_mid_first: got %h want 0000000", obs_vec());
    end
    for (int c = 0; c < 2*FRAME + 8; c++) begin
      @(negedge clk);
      checks++;
      if (sound !== 1'b0 || active !== 3'b000) begin
        errors++; $display("FAIL reset_mid_quiet cyc %0d: sound=%b active=%b want 0/000", c, sound, active);
      end
    end
  endtask

  task automatic test_envelope();
    pulse_reset();
    voice_mode = 6'b110111;
    voice_period = '0; voice_period[PB +: PB] = 16'd5;
    voice_trigger = 3'b010;
    for (int k = 1; k <= 15; k++) begin
      repeat (3) begin
        @(negedge clk);
        voice_trigger = '0;
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL env_model k %0d: got %h want %h", k, obs_vec(), exp_vec());
        end
      end
      env_tick = 1'b1;
      @(negedge clk);
      env_tick = 1'b0;
      checks++;
      if (active[1] !== (k < 15)) begin
        errors++; $display("FAIL env_decay tick %0d: active1=%b want %b", k, active[1], (k < 15));
      end
    end
    voice_trigger = 3'b010; env_tick = 1'b1;
    @(negedge clk);
    voice_trigger = '0; env_tick = 1'b0;
    checks++;
    if (dut.g_voice[1].env_q !== 4'hF || active[1] !== 1'b1) begin
      errors++; $display("FAIL env_trig_tick: env=%h active1=%b want f/1", dut.g_voice[1].env_q, active[1]);
    end
    for (int k = 1; k <= 15; k++) begin
      env_tick = 1'b1;
      @(negedge clk);
      env_tick = 1'b0;
      checks++;
      if (active[1] !== (k < 15) || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL env_retrig tick %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_pwm();
    int hi = 0;
    pulse_reset();
    voice_mode = 6'b011111;
    voice_period = '0; voice_period[2*PB +: PB] = 16'd1;
    voice_trigger = 3'b100;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      voice_trigger = '0;
    end
    voice_period = '0;
    for (int c = 0; c < 2*FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL pwm_model cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (dut.g_voice[2].ramp_q !== 8'h80 || dut.mix_q !== 10'h078) begin
      errors++; $display("FAIL pwm_level: ramp=%h mix=%h want 80/078", dut.g_voice[2].ramp_q, dut.mix_q);
    end
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (sound === 1'b1) hi++;
    end
    checks++;
    if (hi !== 120) begin
      errors++; $display("FAIL pwm_duty: high %0d of %0d want 120", hi, FRAME);
    end
  endtask

  task automatic test_noise_mute();
    pulse_reset();
    voice_mode = 6'b111110;
    voice_period = '0; voice_period[0 +: PB] = 16'd1;
    voice_trigger = 3'b001;
    @(negedge clk);
    voice_trigger = '0;
    checks++;
    if (dut.g_voice[0].lfsr_q !== 15'h7FFE) begin
      errors++; $display("FAIL noise_first_step: got %h want 7ffe", dut.g_voice[0].lfsr_q);
    end
    for (int c = 0; c < 32767; c++) begin
      @(negedge clk);
      checks++;
      if (dut.g_voice[0].lfsr_q == 15'h0 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL noise_step %0d: lfsr=%h got %h want %h", c, dut.g_voice[0].lfsr_q,
                           obs_vec(), exp_vec());
      end
    end
    voice_mode = 6'b111111;
    repeat (2) @(negedge clk);
    checks++;
    if (dut.g_voice[0].vout_q !== 8'h00 || active[0] !== 1'b1) begin
      errors++; $display("FAIL mute: vout=%h active0=%b want 00/1", dut.g_voice[0].vout_q, active[0]);
    end
  endtask

  task automatic test_period_edge();
    pulse_reset();
    voice_mode = 6'b110011;
    voice_period = '0; voice_period[PB +: PB] = 16'd100;
    voice_trigger = 3'b010;
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      voice_trigger = '0;
    end
    checks++;
    if (dut.g_voice[1].phase_q !== 16'd50 || dut.g_voice[1].sq_q !== 1'b1) begin
      errors++; $display("FAIL period_setup: phase=%0d sq=%b want 50/1", dut.g_voice[1].phase_q,
                         dut.g_voice[1].sq_q);
    end
    voice_period[PB +: PB] = 16'd3;
    for (int d = 1; d <= 10; d++) begin
      @(negedge clk);
      checks++;
      if (dut.g_voice[1].sq_q !== (((d - 1) / 3) % 2 == 1) || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL period_edge d %0d: sq=%b want %b", d, dut.g_voice[1].sq_q,
                           (((d - 1) / 3) % 2 == 1));
      end
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int v = 0; v < NV; v++) begin
        voice_trigger[v] = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 63) == 0) voice_mode[2*v +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 63) == 0) voice_period[v*PB +: PB] = 16'($urandom_range(0, 12));
      end
      env_tick = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    voice_trigger = '0; env_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_square();
    test_reset_mid();
    test_envelope();
    test_pwm();
    test_noise_mute();
    test_period_edge();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
